// File: rtl/tt_um_counter_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tt_um_counter_seq_ctrl
// Start/stop/pause controlled modulo-M up/down counter with a wrap limit.
// A start rising edge in IDLE or DONE latches modulus, wrap limit and direction
// and runs the counter. It stops in DONE after W wraps (W = 0 runs forever).
//
// Ports
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   ena     in   global enable, 0 holds every register
//   ui_in   in   [0] start (rising edge), [1] stop, [2] pause, [3] dir (1 = down),
//                [7:4] prescale P
//   uio_in  in   [3:0] modulus M (0/1 treated as 2), [7:4] wrap limit W
//   uo_out  out  [3:0] count, [5:4] state, [6] busy, [7] wrap pulse
//   uio_out out  constant 0
//   uio_oe  out  constant 0 (all uio pins are inputs)
//
// Optional feature macro: COUNTER_SEQ_PRESCALE_EN
//   defined   : P is latched at start and the count steps once every P+1 RUN cycles
//   undefined : the count steps every RUN cycle and ui_in[7:4] is ignored
// -----------------------------------------------------------------------------
module tt_um_counter_seq_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0] state_q, state_d;
  logic [3:0] count_q, count_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic [3:0] m_q, m_d;
  logic [3:0] w_q, w_d;
  logic       dir_q, dir_d;
  logic       busy_q, busy_d;
  logic       wrap_q, wrap_d;
  logic       start_s_q, start_p_q, arm_q;

  logic       stop, pause, start_edge, load, tick, step, wrap_hit, done_hit;
  logic [3:0] m_in, count_step;

`ifdef COUNTER_SEQ_PRESCALE_EN
  logic [3:0] p_q, p_d;
  logic [3:0] presc_q, presc_d;
  assign tick = (presc_q == p_q);
`else
  logic unused_prescale;
  assign unused_prescale = &{1'b0, ui_in[7:4]};
  assign tick = 1'b1;
`endif

  assign stop  = ui_in[1];
  assign pause = ui_in[2];

  // arm_q blocks a start held high across reset from looking like a rising
  // edge: it only sets once start has been seen low.
  assign start_edge = start_s_q & ~start_p_q & arm_q;
  assign load       = start_edge & ~stop & ((state_q == S_IDLE) | (state_q == S_DONE));

  assign m_in = (uio_in[3:0] < 4'd2) ? 4'd2 : uio_in[3:0];

  assign step     = (state_q == S_RUN) & ~stop & ~pause & tick;
  assign wrap_hit = step & (dir_q ? (count_q == 4'd0) : (count_q == m_q - 4'd1));
  assign done_hit = wrap_hit & (w_q != 4'd0) & ((wcnt_q + 4'd1) == w_q);

  always_comb begin
    if (dir_q) count_step = (count_q == 4'd0) ? (m_q - 4'd1) : (count_q - 4'd1);
    else       count_step = (count_q == m_q - 4'd1) ? 4'd0 : (count_q + 4'd1);
  end

  // Next-state logic: stop beats pause beats start.
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (start_edge) state_d = S_RUN;
        S_RUN: begin
          if (pause)         state_d = S_PAUSE;
          else if (done_hit) state_d = S_DONE;
        end
        S_PAUSE: if (!pause) state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Counter datapath and latched configuration.
  always_comb begin
    count_d = count_q;
    wcnt_d  = wcnt_q;
    m_d     = m_q;
    w_d     = w_q;
    dir_d   = dir_q;
`ifdef COUNTER_SEQ_PRESCALE_EN
    p_d     = p_q;
    presc_d = presc_q;
`endif
    if (stop) begin
      count_d = 4'd0;
      wcnt_d  = 4'd0;
`ifdef COUNTER_SEQ_PRESCALE_EN
      presc_d = 4'd0;
`endif
    end else if (load) begin
      count_d = 4'd0;
      wcnt_d  = 4'd0;
      m_d     = m_in;
      w_d     = uio_in[7:4];
      dir_d   = ui_in[3];
`ifdef COUNTER_SEQ_PRESCALE_EN
      p_d     = ui_in[7:4];
      presc_d = 4'd0;
`endif
    end else if (step) begin
      count_d = count_step;
      if (wrap_hit) wcnt_d = wcnt_q + 4'd1;
`ifdef COUNTER_SEQ_PRESCALE_EN
      presc_d = 4'd0;
`endif
    end else if ((state_q == S_RUN) && !pause) begin
`ifdef COUNTER_SEQ_PRESCALE_EN
      presc_d = presc_q + 4'd1;
`endif
    end
  end

  // Output logic, registered alongside the state.
  always_comb begin
    busy_d = (state_d == S_RUN) | (state_d == S_PAUSE);
    wrap_d = wrap_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= 4'd0;
      wcnt_q    <= 4'd0;
      m_q       <= 4'd0;
      w_q       <= 4'd0;
      dir_q     <= 1'b0;
      busy_q    <= 1'b0;
      wrap_q    <= 1'b0;
      start_s_q <= 1'b0;
      start_p_q <= 1'b0;
      arm_q     <= 1'b0;
`ifdef COUNTER_SEQ_PRESCALE_EN
      p_q       <= 4'd0;
      presc_q   <= 4'd0;
`endif
    end else if (ena) begin
      state_q   <= state_d;
      count_q   <= count_d;
      wcnt_q    <= wcnt_d;
      m_q       <= m_d;
      w_q       <= w_d;
      dir_q     <= dir_d;
      busy_q    <= busy_d;
      wrap_q    <= wrap_d;
      start_s_q <= ui_in[0];
      start_p_q <= start_s_q;
      arm_q     <= arm_q | ~ui_in[0];
`ifdef COUNTER_SEQ_PRESCALE_EN
      p_q       <= p_d;
      presc_q   <= presc_d;
`endif
    end
  end

  assign uo_out  = {wrap_q, busy_q, state_q, count_q};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_counter_seq_ctrl.sv
module tb_tt_um_counter_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  tt_um_counter_seq_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v)
      else begin
        errors++;
        $error("FAIL %s: observed %02h expected %02h", tag, obs, exp_v);
      end
  endtask

  // Pulse start for one sampled edge; after this the DUT shows RUN with count 0.
  task automatic start_pulse();
    ui_in[0] = 1'b1;
    clk1();
    ui_in[0] = 1'b0;
    clk1();
  endtask

  function automatic logic [7:0] uo(input logic wrap, input logic busy,
                                    input logic [1:0] st, input logic [3:0] cnt);
    return {wrap, busy, st, cnt};
  endfunction

  initial begin
    logic [3:0] c;
    logic       w;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    #12;
    chk("reset_uo", uo_out, 8'h00);
    chk("reset_uio_out", uio_out, 8'h00);
    chk("reset_uio_oe", uio_oe, 8'h00);
    clk1();
    rst_n = 1'b1;
    clk1();
    chk("idle_after_reset", uo_out, 8'h00);

    // M=6, W=2, up: two wraps then DONE
    uio_in = 8'h26;
    start_pulse();
    chk("m6_first", uo_out, uo(1'b0, 1'b1, 2'd1, 4'd0));
    for (int k = 1; k <= 12; k++) begin
      clk1();
      c = 4'(k % 6);
      w = (k % 6 == 0);
      if (k == 12) chk("m6_done", uo_out, uo(1'b1, 1'b0, 2'd3, 4'd0));
      else         chk("m6_step", uo_out, uo(w, 1'b1, 2'd1, c));
      if (k == 3) uio_in = 8'h0F;  // live change must be ignored
    end
    clk1();
    chk("m6_done_hold", uo_out, uo(1'b0, 1'b0, 2'd3, 4'd0));

    // M=4, W=0, down: restart from DONE, never finishes
    uio_in   = 8'h04;
    ui_in[3] = 1'b1;
    start_pulse();
    chk("m4_first", uo_out, uo(1'b0, 1'b1, 2'd1, 4'd0));
    for (int k = 1; k <= 12; k++) begin
      clk1();
      c = 4'((4 - (k % 4)) % 4);
      w = (k % 4 == 1);
      chk("m4_down", uo_out, uo(w, 1'b1, 2'd1, c));
    end
    ena = 1'b0;
    clk1();
    clk1();
    chk("ena_hold", uo_out, 8'h50);
    ena = 1'b1;
    clk1();
    chk("ena_resume", uo_out, 8'hD3);
    ui_in[1] = 1'b1;
    clk1();
    chk("stop_run", uo_out, 8'h00);
    ui_in[1] = 1'b0;
    ui_in[3] = 1'b0;

    // M=1 behaves as M=2
    uio_in = 8'h01;
    start_pulse();
    chk("m1_first", uo_out, uo(1'b0, 1'b1, 2'd1, 4'd0));
    for (int k = 1; k <= 4; k++) begin
      clk1();
      c = 4'(k % 2);
      w = (k % 2 == 0);
      chk("m1_step", uo_out, uo(w, 1'b1, 2'd1, c));
    end
    ui_in[1] = 1'b1;
    clk1();
    ui_in[1] = 1'b0;

    // Pause at count 2, start ignored in RUN
    uio_in = 8'h08;
    start_pulse();
    clk1();
    clk1();
    chk("pre_pause", uo_out, uo(1'b0, 1'b1, 2'd1, 4'd2));
    ui_in[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      clk1();
      chk("paused", uo_out, uo(1'b0, 1'b1, 2'd2, 4'd2));
    end
    ui_in[2] = 1'b0;
    clk1();
    chk("unpause_no_step", uo_out, uo(1'b0, 1'b1, 2'd1, 4'd2));
    clk1();
    chk("resume_3", uo_out, uo(1'b0, 1'b1, 2'd1, 4'd3));
    ui_in[0] = 1'b1;
    clk1();
    ui_in[0] = 1'b0;
    clk1();
    chk("start_ignored_run", uo_out, uo(1'b0, 1'b1, 2'd1, 4'd5));
    ui_in[1] = 1'b1;
    clk1();
    chk("stop_to_idle", uo_out, 8'h00);
    ui_in[1] = 1'b0;
    clk1();

    // stop and start edge on the same edge from IDLE
    ui_in[0] = 1'b1;
    clk1();
    ui_in[1] = 1'b1;
    clk1();
    chk("stop_beats_start", uo_out, 8'h00);
    ui_in[1] = 1'b0;
    ui_in[0] = 1'b0;
    clk1();
    clk1();
    chk("stop_start_idle", uo_out, 8'h00);

    // reset mid-RUN at count 4, start held across release
    uio_in = 8'h08;
    start_pulse();
    for (int k = 0; k < 4; k++) clk1();
    chk("pre_reset_4", uo_out, uo(1'b0, 1'b1, 2'd1, 4'd4));
    ui_in[0] = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", uo_out, 8'h00);
    clk1();
    clk1();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) clk1();
    chk("no_restart_held", uo_out, 8'h00);
    ui_in[0] = 1'b0;
    clk1();
    start_pulse();
    chk("restart_fresh", uo_out, 8'h50);
    clk1();
    chk("restart_step", uo_out, 8'h51);
    ui_in[1] = 1'b1;
    clk1();
    ui_in[1] = 1'b0;

    // P=2, M=3 prescale
    uio_in = 8'h03;
    ui_in  = 8'h20;
    start_pulse();
    chk("presc_first", uo_out, uo(1'b0, 1'b1, 2'd1, 4'd0));
    for (int k = 1; k <= 6; k++) begin
      clk1();
`ifdef COUNTER_SEQ_PRESCALE_EN
      c = 4'((k / 3) % 3);
`else
      c = 4'(k % 3);
`endif
      chk("presc_count", {4'h0, uo_out[3:0]}, {4'h0, c});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
